// File: rtl/alu_result_bcd.sv
// Converts a captured 16-bit ALU result to packed BCD with a sequential double-dabble engine.
// Div results convert quotient (low byte) and remainder (high byte) as two separate 3-digit numbers.
module alu_result_bcd #(
  parameter logic [2:0] DIV_OPCODE  = 3'b010,
  parameter int         FULL_SHIFTS = 16,
  parameter int         DIV_SHIFTS  = 8
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] Result_in,
  input  logic [2:0]  Instruction_alu,
  input  logic        In_valid,
  output logic        In_ready,
  output logic [23:0] Bcd_out,
  output logic        Div_mode,
  output logic        Out_valid,
  input  logic        Out_ready
);

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        bin_q, bin_d;
  logic [23:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_div_q, mode_div_d;
  logic [23:0]        bcd_out_q, bcd_out_d;
  logic               div_mode_q, div_mode_d;
  logic               out_valid_q, out_valid_d;

  logic [23:0]        bcd_adj;
  logic [23:0]        bcd_shift;
  logic [15:0]        bin_shift;

  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  // Add-3 correction of every digit, done before the shift in the same cycle.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 6; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // Div mode keeps the two bytes and their 12-bit accumulators fully independent.
  always_comb begin
    bcd_shift = '0;
    bin_shift = '0;
    if (mode_div_q) begin
      bcd_shift = {bcd_adj[22:12], bin_q[15], bcd_adj[10:0], bin_q[7]};
      bin_shift = {bin_q[14:8], 1'b0, bin_q[6:0], 1'b0};
    end else begin
      bcd_shift = {4'h0, bcd_adj[18:0], bin_q[15]};
      bin_shift = {bin_q[14:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    mode_div_d  = mode_div_q;
    bcd_out_d   = bcd_out_q;
    div_mode_d  = div_mode_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (In_valid) begin
          bin_d      = Result_in;
          bcd_d      = '0;
          mode_div_d = (Instruction_alu == DIV_OPCODE);
          cnt_d      = (Instruction_alu == DIV_OPCODE) ? CNT_W'(DIV_SHIFTS)
                                                       : CNT_W'(FULL_SHIFTS);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle registers the result; afterwards it is held until accepted.
        if (!out_valid_q) begin
          bcd_out_d   = mode_div_q ? bcd_q : {4'h0, bcd_q[19:0]};
          div_mode_d  = mode_div_q;
          out_valid_d = 1'b1;
        end else if (Out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      mode_div_q  <= 1'b0;
      bcd_out_q   <= '0;
      div_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      mode_div_q  <= mode_div_d;
      bcd_out_q   <= bcd_out_d;
      div_mode_q  <= div_mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Bcd_out   = bcd_out_q;
  assign Div_mode  = div_mode_q;
  assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed, table-driven bench for alu_result_bcd: reset, full/div conversions, latency,
// backpressure, reset mid-conversion and the add-3 digit boundary.
module tb_alu_result_bcd;

  logic        clock = 1'b0;
  logic        resetN;
  logic [15:0] resultIn;
  logic [2:0]  instructionAlu;
  logic        inValid;
  logic        inReady;
  logic [23:0] bcdOut;
  logic        divMode;
  logic        outValid;
  logic        outReady;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] result;
    logic [2:0]  opcode;
    logic [23:0] expBcd;
    logic        expDiv;
    int          expLatency;
  } vector_t;

  vector_t vectors[9];

  alu_result_bcd dut (
    .Clock           (clock),
    .Reset_n         (resetN),
    .Result_in       (resultIn),
    .Instruction_alu (instructionAlu),
    .In_valid        (inValid),
    .In_ready        (inReady),
    .Bcd_out         (bcdOut),
    .Div_mode        (divMode),
    .Out_valid       (outValid),
    .Out_ready       (outReady)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Wait for In_ready, present one request for exactly one accept edge, then scramble inputs.
  task automatic applyStimulus(input logic [15:0] r, input logic [2:0] op);
    int guard;
    guard = 0;
    while (!inReady && guard < 50) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout in_ready=%0b required=1", inReady);
    end
    resultIn       = r;
    instructionAlu = op;
    inValid        = 1'b1;
    @(posedge clock);
    #1;
    inValid        = 1'b0;
    resultIn       = 16'hA5A5;
    instructionAlu = 3'b010;
  endtask

  // Count rising edges after the accept edge until Out_valid is seen (bounded).
  task automatic waitOutValid(output int cycles);
    cycles = 0;
    while (!outValid && cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int seen;

    vectors[0] = '{"full_65535",  16'd65535, 3'b011, 24'h065535, 1'b0, 17};
    vectors[1] = '{"div_FEFF",    16'hFEFF,  3'b010, 24'h254255, 1'b1, 9};
    vectors[2] = '{"div_zero",    16'h0000,  3'b010, 24'h000000, 1'b1, 9};
    vectors[3] = '{"full_9999",   16'd9999,  3'b000, 24'h009999, 1'b0, 17};
    vectors[4] = '{"full_10000",  16'd10000, 3'b111, 24'h010000, 1'b0, 17};
    vectors[5] = '{"div_0A63",    16'h0A63,  3'b010, 24'h010099, 1'b1, 9};
    vectors[6] = '{"full_one",    16'd1,     3'b001, 24'h000001, 1'b0, 17};
    vectors[7] = '{"full_zero",   16'd0,     3'b000, 24'h000000, 1'b0, 17};
    vectors[8] = '{"full_div_pat",16'hFEFF,  3'b110, 24'h065279, 1'b0, 17};

    resetN         = 1'b0;
    resultIn       = '0;
    instructionAlu = '0;
    inValid        = 1'b0;
    outReady       = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_bcd",       32'(bcdOut),   32'h0);
    checkOutput("reset_out_valid", 32'(outValid), 32'h0);
    checkOutput("reset_div_mode",  32'(divMode),  32'h0);
    checkOutput("reset_in_ready",  32'(inReady),  32'h1);
    resetN = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 9; i++) begin
      outReady = 1'b1;
      applyStimulus(vectors[i].result, vectors[i].opcode);
      checkOutput({vectors[i].name, "_busy"}, 32'(inReady), 32'h0);
      waitOutValid(lat);
      checkOutput({vectors[i].name, "_latency"}, 32'(lat), 32'(vectors[i].expLatency));
      checkOutput({vectors[i].name, "_bcd"}, 32'(bcdOut), 32'(vectors[i].expBcd));
      checkOutput({vectors[i].name, "_div"}, 32'(divMode), 32'(vectors[i].expDiv));
      @(posedge clock);
      #1;
      checkOutput({vectors[i].name, "_valid_drop"}, 32'(outValid), 32'h0);
      checkOutput({vectors[i].name, "_bcd_hold"}, 32'(bcdOut), 32'(vectors[i].expBcd));
    end

    // Backpressure: hold the result for five edges and ignore a stray request.
    outReady = 1'b0;
    applyStimulus(16'd12345, 3'b000);
    waitOutValid(lat);
    checkOutput("bp_latency", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        inValid  = 1'b1;
        resultIn = 16'd777;
      end
      @(posedge clock);
      #1;
      inValid = 1'b0;
      checkOutput("bp_valid_held", 32'(outValid), 32'h1);
      checkOutput("bp_bcd_held",   32'(bcdOut),   32'h012345);
      checkOutput("bp_in_ready",   32'(inReady),  32'h0);
    end
    outReady = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp_valid_drop", 32'(outValid), 32'h0);
    checkOutput("bp_in_ready_back", 32'(inReady), 32'h1);
    seen = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (outValid) seen++;
    end
    checkOutput("bp_stray_ignored", 32'(seen), 32'h0);
    checkOutput("bp_bcd_kept", 32'(bcdOut), 32'h012345);

    // Reset at T+5 of a full conversion discards it.
    applyStimulus(16'd54321, 3'b000);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    resetN = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    checkOutput("midrst_out_valid", 32'(outValid), 32'h0);
    checkOutput("midrst_in_ready",  32'(inReady),  32'h1);
    checkOutput("midrst_bcd",       32'(bcdOut),   32'h0);
    seen = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (outValid) seen++;
    end
    checkOutput("midrst_no_output", 32'(seen), 32'h0);
    applyStimulus(16'd100, 3'b000);
    waitOutValid(lat);
    checkOutput("midrst_latency", 32'(lat), 32'd17);
    checkOutput("midrst_bcd_100", 32'(bcdOut), 32'h000100);
    checkOutput("midrst_div",     32'(divMode), 32'h0);
    @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
